// File: rtl/noc_mon_pkg.sv
// Shared types and helpers for the NoC receive-side monitor.
// Holds the monitor state encoding, the saturation constant and a generic popcount.
package noc_mon_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RUN     = 3'd1,
    ST_DRAIN   = 3'd2,
    ST_DONE    = 3'd3,
    ST_TIMEOUT = 3'd4
  } mon_state_e;

  // Widest counter supported; modules slice the low CNT_W bits.
  localparam logic [63:0] CNT_SAT = '1;

  localparam int POP_MAX_N = 256;

  function automatic int unsigned popcount(input logic [POP_MAX_N-1:0] v);
    int unsigned n;
    n = 0;
    for (int i = 0; i < POP_MAX_N; i++) begin
      n = n + int'(v[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/noc_popcount.sv
// Combinational balanced adder tree: counts set bits of an N-bit vector.
// Inputs are padded to a power of two; each level halves the operand count.
module noc_popcount #(
  parameter int N = 16
) (
  input  logic [N-1:0]             i_bits,
  output logic [$clog2(N+1)-1:0]   o_count
);

  localparam int OUT_W = $clog2(N + 1);
  localparam int P     = (N < 2) ? 2 : (1 << $clog2(N));
  localparam int L     = $clog2(P);

  for (genvar l = 0; l <= L; l++) begin : g_lvl
    localparam int W = P >> l;
    logic [OUT_W-1:0] w_sum [W];

    if (l == 0) begin : g_leaf
      for (genvar i = 0; i < P; i++) begin : g_i
        if (i < N) begin : g_in
          assign w_sum[i] = OUT_W'(i_bits[i]);
        end else begin : g_pad
          assign w_sum[i] = '0;
        end
      end
    end else begin : g_add
      for (genvar i = 0; i < W; i++) begin : g_i
        assign w_sum[i] = g_lvl[l-1].w_sum[2*i] + g_lvl[l-1].w_sum[2*i+1];
      end
    end
  end

  assign o_count = g_lvl[L].w_sum[0];

endmodule

// File: rtl/noc_rx_monitor.sv
// Receive-side NoC monitor: counts real ejection handshakes, flags misrouted packets,
// and sequences end-of-test through a drain window and an inactivity watchdog.
module noc_rx_monitor
  import noc_mon_pkg::*;
#(
  parameter int NUM_PE         = 16,
  parameter int DATA_W         = 32,
  parameter int ADDR_W         = 4,
  parameter int ADDR_LSB       = 0,
  parameter int CNT_W          = 32,
  parameter int EXPECTED       = 1600,
  parameter int DRAIN_CYCLES   = 100,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         i_start,
  input  logic [NUM_PE*DATA_W-1:0]     i_data,
  input  logic [NUM_PE-1:0]            i_valid,
  input  logic [NUM_PE-1:0]            i_ready,
  input  logic [$clog2(NUM_PE)-1:0]    i_sel,
  output logic [CNT_W-1:0]             o_sel_cnt,
  output logic [CNT_W-1:0]             o_total,
  output logic [CNT_W-1:0]             o_misroute_cnt,
  output logic                         o_done,
  output logic                         o_finished,
  output logic                         o_timeout,
  output logic                         o_overflow
);

  localparam int PC_W = $clog2(NUM_PE + 1);
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam int DR_W = $clog2(DRAIN_CYCLES + 1);

  localparam logic [CNT_W-1:0] SAT     = CNT_SAT[CNT_W-1:0];
  localparam logic [CNT_W-1:0] EXP     = CNT_W'(EXPECTED);
  localparam logic [WD_W-1:0]  WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);
  localparam logic [DR_W-1:0]  DR_LAST = DR_W'(DRAIN_CYCLES - 1);

  mon_state_e       r_state;
  logic [CNT_W-1:0] r_total;
  logic [CNT_W-1:0] r_misroute;
  logic [CNT_W-1:0] r_sel_cnt;
  logic [WD_W-1:0]  r_wd;
  logic [DR_W-1:0]  r_drain;
  logic             r_done;
  logic             r_finished;
  logic             r_timeout;
  logic             r_overflow;

  logic [NUM_PE-1:0] w_hs;
  logic [NUM_PE-1:0] w_mis;
  logic [PC_W-1:0]   w_hs_cnt;
  logic [PC_W-1:0]   w_mis_cnt;
  logic              w_any_hs;
  logic              w_counting;
  logic              w_clear;
  logic [CNT_W-1:0]  w_total_nxt;
  logic [CNT_W-1:0]  w_mis_nxt;
  logic [CNT_W-1:0]  w_ch_nxt [NUM_PE];
  logic              w_unused_data;

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                               input logic [PC_W-1:0]  b);
    logic [CNT_W:0] s;
    s = {1'b0, a} + (CNT_W+1)'(b);
    return s[CNT_W] ? SAT : s[CNT_W-1:0];
  endfunction

  // A transfer happens only when both sides agree; valid alone is not traffic.
  assign w_hs       = i_valid & i_ready;
  assign w_any_hs   = |w_hs;
  assign w_counting = (r_state == ST_RUN) || (r_state == ST_DRAIN);
  assign w_clear    = i_start && (r_state inside {ST_IDLE, ST_DONE, ST_TIMEOUT});

  noc_popcount #(.N(NUM_PE)) u_hs_pop (
    .i_bits  (w_hs),
    .o_count (w_hs_cnt)
  );

  assign w_mis_cnt   = PC_W'(popcount(POP_MAX_N'(w_mis)));
  assign w_total_nxt = w_counting ? sat_add(r_total, w_hs_cnt) : r_total;
  assign w_mis_nxt   = w_counting ? sat_add(r_misroute, w_mis_cnt) : r_misroute;

  // Payload bits outside the destination field are observed but never interpreted.
  assign w_unused_data = ^i_data;

  for (genvar ch = 0; ch < NUM_PE; ch++) begin : g_ch
    localparam logic [ADDR_W-1:0] CH_ID = ADDR_W'(ch);
    logic [ADDR_W-1:0] w_dest;
    logic [CNT_W-1:0]  r_cnt;

    assign w_dest      = i_data[ch*DATA_W+ADDR_LSB +: ADDR_W];
    assign w_mis[ch]   = w_hs[ch] && (w_dest != CH_ID);
    assign w_ch_nxt[ch] = (w_counting && w_hs[ch] && (r_cnt != SAT)) ? r_cnt + 1'b1 : r_cnt;

    always_ff @(posedge clk) begin
      if (rst || w_clear) r_cnt <= '0;
      else                r_cnt <= w_ch_nxt[ch];
    end
  end

  // Readback takes the post-update value so it lines up with o_total.
  always_ff @(posedge clk) begin
    if (rst || w_clear) r_sel_cnt <= '0;
    else                r_sel_cnt <= w_ch_nxt[i_sel];
  end

  // NOTE: all state updates use non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_total    <= '0;
      r_misroute <= '0;
      r_wd       <= '0;
      r_drain    <= '0;
      r_done     <= 1'b0;
      r_finished <= 1'b0;
      r_timeout  <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE, ST_TIMEOUT: begin
          if (i_start) begin
            r_state    <= ST_RUN;
            r_total    <= '0;
            r_misroute <= '0;
            r_wd       <= '0;
            r_drain    <= '0;
            r_done     <= 1'b0;
            r_finished <= 1'b0;
            r_timeout  <= 1'b0;
            r_overflow <= 1'b0;
          end
        end
        ST_RUN: begin
          r_total    <= w_total_nxt;
          r_misroute <= w_mis_nxt;
          // Reaching the target wins over the watchdog in the same cycle.
          if (w_total_nxt >= EXP) begin
            r_state <= ST_DRAIN;
            r_done  <= 1'b1;
            r_drain <= '0;
            if (w_total_nxt > EXP) r_overflow <= 1'b1;
          end else if (!w_any_hs && (r_wd == WD_LAST)) begin
            r_state    <= ST_TIMEOUT;
            r_timeout  <= 1'b1;
            r_finished <= 1'b1;
          end else begin
            r_wd <= w_any_hs ? '0 : r_wd + 1'b1;
          end
        end
        ST_DRAIN: begin
          r_total    <= w_total_nxt;
          r_misroute <= w_mis_nxt;
          if (w_any_hs) r_overflow <= 1'b1;
          if (r_drain == DR_LAST) begin
            r_state    <= ST_DONE;
            r_finished <= 1'b1;
          end else begin
            r_drain <= r_drain + 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_sel_cnt      = r_sel_cnt;
  assign o_total        = r_total;
  assign o_misroute_cnt = r_misroute;
  assign o_done         = r_done;
  assign o_finished     = r_finished;
  assign o_timeout      = r_timeout;
  assign o_overflow     = r_overflow;

endmodule

// File: tb/tb_noc_rx_monitor.sv
// Directed bench for noc_rx_monitor: short target/drain/watchdog settings so every
// end-of-test path is reachable in a few hundred cycles.
module tb_noc_rx_monitor;
  import noc_mon_pkg::*;

  localparam int NUM_PE   = 16;
  localparam int DATA_W   = 32;
  localparam int CNT_W    = 32;
  localparam int DRAIN    = 6;
  localparam int TIMEOUT  = 50;

  logic                      clk;
  logic                      rst;
  logic                      i_start;
  logic [NUM_PE*DATA_W-1:0]  i_data;
  logic [NUM_PE-1:0]         i_valid;
  logic [NUM_PE-1:0]         i_ready;
  logic [3:0]                i_sel;
  logic [CNT_W-1:0]          o_sel_cnt;
  logic [CNT_W-1:0]          o_total;
  logic [CNT_W-1:0]          o_misroute_cnt;
  logic                      o_done;
  logic                      o_finished;
  logic                      o_timeout;
  logic                      o_overflow;

  int n_tests = 0;
  int n_fail  = 0;

  noc_rx_monitor #(
    .NUM_PE(NUM_PE), .DATA_W(DATA_W), .ADDR_W(4), .ADDR_LSB(0), .CNT_W(CNT_W),
    .EXPECTED(20), .DRAIN_CYCLES(DRAIN), .TIMEOUT_CYCLES(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst), .i_start(i_start), .i_data(i_data),
    .i_valid(i_valid), .i_ready(i_ready), .i_sel(i_sel),
    .o_sel_cnt(o_sel_cnt), .o_total(o_total), .o_misroute_cnt(o_misroute_cnt),
    .o_done(o_done), .o_finished(o_finished), .o_timeout(o_timeout),
    .o_overflow(o_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int ch, input int dest, input logic rdy);
    i_valid[ch] = 1'b1;
    i_ready[ch] = rdy;
    i_data[ch*DATA_W +: DATA_W] = 32'(dest);
  endtask

  task automatic idle_in();
    i_valid = '0;
    i_ready = '0;
    i_data  = '0;
  endtask

  task automatic pulse_start();
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
  endtask

  initial begin
    rst = 1'b1; i_start = 1'b0; i_sel = '0;
    idle_in();
    tick(); tick();
    check("rst_total", o_total, 0);
    check("rst_sel", o_sel_cnt, 0);
    check("rst_misroute", o_misroute_cnt, 0);
    check("rst_flags", {o_done, o_finished, o_timeout, o_overflow}, 0);
    check("rst_state", 64'(dut.r_state), 64'(ST_IDLE));
    rst = 1'b0;
    tick();

    pulse_start();
    check("start_state", 64'(dut.r_state), 64'(ST_RUN));

    // valid without ready is not a handshake
    drive(0, 0, 1'b0);
    repeat (10) tick();
    idle_in();
    check("noready_total", o_total, 0);

    // five handshakes on ch3
    i_sel = 4'd3;
    drive(3, 3, 1'b1);
    repeat (5) tick();
    idle_in();
    check("ch3_total", o_total, 5);
    check("ch3_sel", o_sel_cnt, 5);
    check("ch3_misroute", o_misroute_cnt, 0);
    check("ch3_state", 64'(dut.r_state), 64'(ST_RUN));

    // dest 7 arriving on ch2
    i_sel = 4'd2;
    drive(2, 7, 1'b1);
    tick();
    idle_in();
    check("mis_cnt", o_misroute_cnt, 1);
    check("mis_ch2", o_sel_cnt, 1);
    check("mis_total", o_total, 6);

    // start while running must not restart
    pulse_start();
    check("start_in_run", o_total, 6);

    // 12 handshakes in one cycle: 6 -> 18
    i_sel = 4'd3;
    for (int ch = 4; ch < 16; ch++) drive(ch, ch, 1'b1);
    tick();
    idle_in();
    check("wide_total", o_total, 18);
    check("wide_ch3", o_sel_cnt, 5);
    check("wide_done", o_done, 0);

    // 4 more crosses 20 -> 22 with overflow
    for (int ch = 0; ch < 4; ch++) drive(ch, ch, 1'b1);
    tick();
    idle_in();
    check("cross_total", o_total, 22);
    check("cross_overflow", o_overflow, 1);
    check("cross_done", o_done, 1);
    check("cross_finished", o_finished, 0);
    check("cross_ch3", o_sel_cnt, 6);
    repeat (DRAIN - 1) tick();
    check("drain_early", o_finished, 0);
    tick();
    check("drain_finished", o_finished, 1);
    check("drain_done_held", o_done, 1);
    check("drain_timeout", o_timeout, 0);

    // watchdog: no traffic after start
    pulse_start();
    check("wd_clear_total", o_total, 0);
    check("wd_clear_ovf", o_overflow, 0);
    check("wd_clear_fin", o_finished, 0);
    repeat (TIMEOUT - 1) tick();
    check("wd_early", o_timeout, 0);
    tick();
    check("wd_timeout", o_timeout, 1);
    check("wd_finished", o_finished, 1);
    check("wd_done", o_done, 0);

    // exact hit of 20, then a handshake inside the drain window
    pulse_start();
    for (int ch = 0; ch < 16; ch++) drive(ch, ch, 1'b1);
    tick();
    idle_in();
    check("exact_16", o_total, 16);
    for (int ch = 0; ch < 4; ch++) drive(ch, ch, 1'b1);
    tick();
    idle_in();
    check("exact_total", o_total, 20);
    check("exact_overflow", o_overflow, 0);
    check("exact_done", o_done, 1);
    drive(0, 0, 1'b1);
    tick();
    idle_in();
    check("drain_hs_total", o_total, 21);
    check("drain_hs_overflow", o_overflow, 1);
    repeat (DRAIN - 1) tick();
    check("exact_finished", o_finished, 1);
    drive(5, 5, 1'b1);
    tick();
    idle_in();
    check("frozen_total", o_total, 21);

    // reset in the middle of a run
    pulse_start();
    for (int ch = 0; ch < 9; ch++) drive(ch, ch, 1'b1);
    tick();
    idle_in();
    check("pre_rst_total", o_total, 9);
    rst = 1'b1;
    tick();
    check("mid_rst_total", o_total, 0);
    check("mid_rst_sel", o_sel_cnt, 0);
    check("mid_rst_flags", {o_done, o_finished, o_timeout, o_overflow}, 0);
    check("mid_rst_state", 64'(dut.r_state), 64'(ST_IDLE));
    rst = 1'b0;
    tick();

    pulse_start();
    i_sel = 4'd5;
    for (int ch = 5; ch < 8; ch++) drive(ch, ch, 1'b1);
    tick();
    idle_in();
    check("post_rst_total", o_total, 3);
    check("post_rst_ch5", o_sel_cnt, 1);
    check("post_rst_misroute", o_misroute_cnt, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/noc_rx_monitor.md
# noc_rx_monitor

Synthesisable, parametrised receive-side monitor for the HNoC PE array. It observes every PE ejection port and counts only real handshakes (valid and ready both high), not valid pulses. It checks each packet's destination field against the port it arrived on, keeps per-channel and total counts, and sequences end-of-test with a drain window and an inactivity watchdog. It sits beside the NoC in simulation and on-chip test builds; it observes only and never drives NoC handshakes.

## Interface
- NUM_PE, 16: number of monitored ejection ports.
- DATA_W, 32: flit width.
- ADDR_W, 4: destination field width; must be ≥ clog2(NUM_PE).
- ADDR_LSB, 0: destination field is i_data[ch*DATA_W+ADDR_LSB +: ADDR_W].
- CNT_W, 32: width of all counters.
- EXPECTED, 1600: total handshakes that complete the test.
- DRAIN_CYCLES, 100: cycles spent in DRAIN before DONE.
- TIMEOUT_CYCLES, 100000: handshake-free RUN cycles before TIMEOUT.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- i_start  in  1  pulse; arms the monitor from IDLE.
- i_data  in  NUM_PE*DATA_W  ejected flits, channel ch at [ch*DATA_W +: DATA_W].
- i_valid  in  NUM_PE  NoC-side valid per channel.
- i_ready  in  NUM_PE  PE-side ready per channel.
- i_sel  in  clog2(NUM_PE)  channel select for count readback.
- o_sel_cnt  out  CNT_W  handshake count of channel i_sel.
- o_total  out  CNT_W  total counted handshakes.
- o_misroute_cnt  out  CNT_W  packets whose destination field ≠ channel index.
- o_done  out  1  high in DRAIN and DONE.
- o_finished  out  1  high in DONE or TIMEOUT.
- o_timeout  out  1  high in TIMEOUT.
- o_overflow  out  1  sticky; total exceeded EXPECTED.

## Operation
- States: IDLE, RUN, DRAIN, DONE, TIMEOUT.
- IDLE: no counting. i_start → RUN; counters, watchdog and o_overflow clear on this transition.
- RUN: each cycle, hs = i_valid & i_ready; total += popcount(hs). Each channel counter increments on its hs bit. If dest ≠ ch for an hs channel, misroute += 1 per channel in that cycle.
- RUN → DRAIN when the next total ≥ EXPECTED. If the next total > EXPECTED, set o_overflow.
- RUN → TIMEOUT when the watchdog reaches TIMEOUT_CYCLES−1 in a cycle with hs == 0. Any handshake resets the watchdog to 0.
- DRAIN: keep counting. Any handshake in DRAIN sets o_overflow. The drain counter reaches DRAIN_CYCLES−1 → DONE.
- DONE, TIMEOUT: counting frozen. i_start → RUN, a fresh test.
- All counters saturate at 2^CNT_W−1; they never wrap.
- i_start in RUN or DRAIN is ignored.
- Reset mid-test returns to IDLE with every counter cleared.

## Timing
- All outputs are registered. Counts reflect handshakes up to and including the previous clock edge, which is 1-cycle latency.
- o_sel_cnt is a registered mux of the channel counters and reflects i_sel one cycle later.
- o_done rises in the cycle after the handshake that reaches EXPECTED. o_finished rises exactly DRAIN_CYCLES cycles after o_done.
- Reset values: state IDLE; o_total, o_sel_cnt, o_misroute_cnt all 0; o_done, o_finished, o_timeout, o_overflow all 0.
- Simultaneous events:
  - Multiple handshakes in one cycle are all counted.
  - A cycle that crosses EXPECTED and also handshakes is still RUN→DRAIN; the watchdog does not fire.

## Structure
- Package noc_mon_pkg holds the state enum, the popcount function, and CNT_SAT (the saturation constant).
- Sub-module noc_popcount is a registered-free adder tree, NUM_PE → clog2(NUM_PE+1) bits.
- Per-channel counters are a generate loop inside noc_rx_monitor.

## Test plan
- Single channel: reset, start, 5 handshakes on ch3 with correct dest → o_total=5, o_sel_cnt(i_sel=3)=5, misroute 0, state RUN.
- Valid without ready: i_valid[0]=1, i_ready[0]=0 for 10 cycles → o_total stays 0.
- Wide cycle crossing EXPECTED: EXPECTED=20, total at 18, 4 handshakes in one cycle → o_total=22, o_overflow=1, o_done next cycle, o_finished DRAIN_CYCLES later.
- Misroute: flit with dest=7 accepted on ch2 → o_misroute_cnt=1, ch2 count=1.
- Watchdog: TIMEOUT_CYCLES=50, no traffic after start → o_timeout=1 and o_finished=1 at cycle 50, o_done=0.
- Reset mid-RUN with total=9 → next cycle all outputs 0 and state IDLE. A following i_start and 3 handshakes → o_total=3.
